// File: rtl/cam_sequencer.sv
// cam_sequencer: OV7670 bring-up, SCCB config with retry-on-timeout, VSYNC-aligned capture gating
// Ports: i_clk/i_rstn clock and async active-low reset; i_go start/rearm pulse; i_mode 0=continuous 1=snapshot;
//        i_abort stop capture; i_vsync camera frame sync (async); i_cfg_done config engine done;
//        o_cam_reset/o_pwdn camera pins; o_cfg_rst/o_cfg_start config engine control;
//        o_capture_en capture gate; o_busy/o_error/o_frame_cnt/o_state status.
module cam_sequencer #(
    parameter int RESET_CYCLES       = 100_000,
    parameter int SETTLE_CYCLES      = 1_000_000,
    parameter int CFG_TIMEOUT_CYCLES = 10_000_000,
    parameter int MAX_RETRIES        = 3,
    parameter int FRAME_CNT_W        = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic                   i_go,
    input  logic                   i_mode,
    input  logic                   i_abort,
    input  logic                   i_vsync,
    input  logic                   i_cfg_done,
    output logic                   o_cam_reset,
    output logic                   o_pwdn,
    output logic                   o_cfg_rst,
    output logic                   o_cfg_start,
    output logic                   o_capture_en,
    output logic                   o_busy,
    output logic                   o_error,
    output logic [FRAME_CNT_W-1:0] o_frame_cnt,
    output logic [3:0]             o_state
);
    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_RST_HOLD  = 4'd1,
        S_SETTLE    = 4'd2,
        S_CFG_START = 4'd3,
        S_CFG_WAIT  = 4'd4,
        S_ARM       = 4'd5,
        S_CAPTURE   = 4'd6,
        S_HOLD      = 4'd7,
        S_ERROR     = 4'd8
    } state_t;

    localparam int MAX_A   = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
    localparam int MAX_CYC = (MAX_A > CFG_TIMEOUT_CYCLES) ? MAX_A : CFG_TIMEOUT_CYCLES;
    localparam int TW      = $clog2(MAX_CYC + 1);
    localparam int RW      = $clog2(MAX_RETRIES + 1);

    state_t                 r_state, w_next;
    logic [TW-1:0]          r_timer, w_timer;
    logic [RW-1:0]          r_retry, w_retry;
    logic                   r_mode, w_mode;
    logic [FRAME_CNT_W-1:0] r_frame_cnt, w_frame_cnt;
    logic [1:0]             r_vs_sync;
    logic                   r_vs_prev, r_vs_rise;
    logic                   r_cam_reset, r_pwdn, r_cfg_rst, r_cfg_start, r_capture_en, r_busy, r_error;
    logic                   w_cam_off;

    // r_vs_rise is a registered one-cycle pulse, three clocks after i_vsync rises
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_vs_sync <= '0;
            r_vs_prev <= 1'b0;
            r_vs_rise <= 1'b0;
        end else begin
            r_vs_sync <= {r_vs_sync[0], i_vsync};
            r_vs_prev <= r_vs_sync[1];
            r_vs_rise <= r_vs_sync[1] & ~r_vs_prev;
        end
    end

    // timer clears on every transition and in untimed states, so each timed state starts at 0
    always_comb begin
        w_next      = r_state;
        w_timer     = '0;
        w_retry     = r_retry;
        w_mode      = r_mode;
        w_frame_cnt = r_frame_cnt;
        case (r_state)
            S_IDLE: if (i_go) begin
                w_next  = S_RST_HOLD;
                w_retry = '0;
            end
            S_RST_HOLD: if (r_timer == TW'(RESET_CYCLES - 1)) w_next = S_SETTLE;
                        else w_timer = r_timer + TW'(1);
            S_SETTLE: if (r_timer == TW'(SETTLE_CYCLES - 1)) w_next = S_CFG_START;
                      else w_timer = r_timer + TW'(1);
            S_CFG_START: w_next = S_CFG_WAIT;
            S_CFG_WAIT: if (i_cfg_done) w_next = S_ARM;
                else if (r_timer == TW'(CFG_TIMEOUT_CYCLES - 1)) begin
                    w_retry = r_retry + RW'(1);
                    w_next  = (w_retry < RW'(MAX_RETRIES)) ? S_RST_HOLD : S_ERROR;
                end else w_timer = r_timer + TW'(1);
            S_ARM: if (i_abort) w_next = S_HOLD;
                   else if (r_vs_rise) w_next = S_CAPTURE;
            S_CAPTURE: if (i_abort) w_next = S_HOLD;
                else if (r_vs_rise) begin
                    w_frame_cnt = (&r_frame_cnt) ? r_frame_cnt : r_frame_cnt + FRAME_CNT_W'(1);
                    if (r_mode) w_next = S_HOLD;
                end
            S_HOLD: if (i_go) w_next = S_ARM;
            S_ERROR: if (i_go) begin
                w_next  = S_RST_HOLD;
                w_retry = '0;
            end
            default: w_next = S_IDLE;
        endcase
        if (w_next == S_ARM && r_state != S_ARM) begin
            w_mode      = i_mode;
            w_frame_cnt = '0;
        end
    end

    // outputs are decoded from the next state so they are valid in the first cycle of each state
    assign w_cam_off = (w_next == S_IDLE) || (w_next == S_RST_HOLD) || (w_next == S_ERROR);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_retry      <= '0;
            r_mode       <= 1'b0;
            r_frame_cnt  <= '0;
            r_cam_reset  <= 1'b0;
            r_pwdn       <= 1'b1;
            r_cfg_rst    <= 1'b1;
            r_cfg_start  <= 1'b0;
            r_capture_en <= 1'b0;
            r_busy       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_timer      <= w_timer;
            r_retry      <= w_retry;
            r_mode       <= w_mode;
            r_frame_cnt  <= w_frame_cnt;
            r_cam_reset  <= ~w_cam_off;
            r_pwdn       <= (w_next == S_IDLE);
            r_cfg_rst    <= w_cam_off;
            r_cfg_start  <= (w_next == S_CFG_START);
            r_capture_en <= (w_next == S_CAPTURE);
            r_busy       <= ~((w_next == S_IDLE) || (w_next == S_HOLD) || (w_next == S_ERROR));
            r_error      <= (w_next == S_ERROR);
        end
    end

    assign o_cam_reset  = r_cam_reset;
    assign o_pwdn       = r_pwdn;
    assign o_cfg_rst    = r_cfg_rst;
    assign o_cfg_start  = r_cfg_start;
    assign o_capture_en = r_capture_en;
    assign o_busy       = r_busy;
    assign o_error      = r_error;
    assign o_frame_cnt  = r_frame_cnt;
    assign o_state      = r_state;
endmodule

// File: tb/tb_cam_sequencer.sv
// tb_cam_sequencer: directed plus randomized checks of cam_sequencer against a behavioural model
module tb_cam_sequencer;
    localparam int RC = 4, SC = 8, TC = 50, MR = 2, FW = 16;
    localparam int IDLE = 0, RST_HOLD = 1, SETTLE = 2, CFG_START = 3, CFG_WAIT = 4,
                   ARM = 5, CAPTURE = 6, HOLD = 7, ERR = 8;

    logic i_clk = 1'b0, i_rstn = 1'b0, i_go = 1'b0, i_mode = 1'b0, i_abort = 1'b0;
    logic i_vsync = 1'b0, i_cfg_done = 1'b0;
    logic o_cam_reset, o_pwdn, o_cfg_rst, o_cfg_start, o_capture_en, o_busy, o_error;
    logic [FW-1:0] o_frame_cnt;
    logic [3:0] o_state;

    cam_sequencer #(
        .RESET_CYCLES(RC), .SETTLE_CYCLES(SC), .CFG_TIMEOUT_CYCLES(TC),
        .MAX_RETRIES(MR), .FRAME_CNT_W(FW)
    ) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_go(i_go), .i_mode(i_mode), .i_abort(i_abort),
        .i_vsync(i_vsync), .i_cfg_done(i_cfg_done), .o_cam_reset(o_cam_reset), .o_pwdn(o_pwdn),
        .o_cfg_rst(o_cfg_rst), .o_cfg_start(o_cfg_start), .o_capture_en(o_capture_en),
        .o_busy(o_busy), .o_error(o_error), .o_frame_cnt(o_frame_cnt), .o_state(o_state)
    );

    always #5 i_clk = ~i_clk;

    int n_tests = 0, n_fail = 0;
    int cs_cnt = 0, cap_cnt = 0, vs_left = 0;

    // model: phase, cycles spent in the phase, retries, latched mode, frames, i_vsync sample history
    int m_st = IDLE, m_t = 0, m_retry = 0, m_fc = 0, m_nx;
    logic m_mode = 1'b0, m_rise;
    logic [3:0] m_hist = '0;

    task automatic model_reset();
        m_st = IDLE; m_t = 0; m_retry = 0; m_fc = 0; m_mode = 1'b0; m_hist = '0;
    endtask

    task automatic model_step();
        // the edge seen by the sequencer now is the i_vsync rise sampled three to four edges ago
        m_rise = m_hist[2] & ~m_hist[3];
        m_nx = m_st;
        case (m_st)
            IDLE, ERR: if (i_go) begin m_nx = RST_HOLD; m_retry = 0; m_t = 0; end
            RST_HOLD: begin m_t++; if (m_t == RC) begin m_nx = SETTLE; m_t = 0; end end
            SETTLE: begin m_t++; if (m_t == SC) begin m_nx = CFG_START; m_t = 0; end end
            CFG_START: begin m_nx = CFG_WAIT; m_t = 0; end
            CFG_WAIT: if (i_cfg_done) m_nx = ARM;
                else begin
                    m_t++;
                    if (m_t == TC) begin m_retry++; m_nx = (m_retry < MR) ? RST_HOLD : ERR; m_t = 0; end
                end
            ARM: if (i_abort) m_nx = HOLD; else if (m_rise) m_nx = CAPTURE;
            CAPTURE: if (i_abort) m_nx = HOLD;
                else if (m_rise) begin
                    if (m_fc < (1 << FW) - 1) m_fc++;
                    if (m_mode) m_nx = HOLD;
                end
            HOLD: if (i_go) m_nx = ARM;
            default: m_nx = IDLE;
        endcase
        if (m_nx == ARM && m_st != ARM) begin m_mode = i_mode; m_fc = 0; end
        m_st = m_nx;
        m_hist = {m_hist[2:0], i_vsync};
    endtask

    task automatic cmp_model();
        logic [26:0] got, exp;
        logic off;
        off = (m_st == IDLE) || (m_st == RST_HOLD) || (m_st == ERR);
        exp = {4'(m_st), m_st == ERR, !(m_st == IDLE || m_st == HOLD || m_st == ERR), m_st == CAPTURE,
               m_st == CFG_START, off, m_st == IDLE, !off, FW'(m_fc)};
        got = {o_state, o_error, o_busy, o_capture_en, o_cfg_start, o_cfg_rst, o_pwdn, o_cam_reset, o_frame_cnt};
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL model_cycle t=%0t dut=%h model=%h (state,err,busy,cap,start,cfgrst,pwdn,camrst,frames)",
                     $time, got, exp);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge i_clk);
            if (!i_rstn) model_reset(); else model_step();
            #1;
            cmp_model();
            cs_cnt += int'(o_cfg_start);
            cap_cnt += int'(o_capture_en);
        end
    endtask

    task automatic go_pulse();
        i_go = 1'b1; tick(1); i_go = 1'b0;
    endtask

    task automatic vs_pulse(input int hi, input int lo);
        i_vsync = 1'b1; tick(hi); i_vsync = 1'b0; tick(lo);
    endtask

    initial begin
        int cs0;
        tick(3);
        i_rstn = 1'b1;
        tick(2);
        chk("idle_state", 32'(o_state), IDLE);
        chk("idle_pwdn", 32'(o_pwdn), 1);
        chk("idle_cam_reset", 32'(o_cam_reset), 0);

        // power-up: camera reset low for RC cycles, config start SC cycles after release
        go_pulse();
        for (int i = 0; i < RC; i++) begin
            chk("hold_cam_reset_low", 32'(o_cam_reset), 0);
            chk("hold_busy", 32'(o_busy), 1);
            tick(1);
        end
        chk("cam_reset_released", 32'(o_cam_reset), 1);
        for (int i = 0; i < SC; i++) begin
            chk("no_early_cfg_start", 32'(o_cfg_start), 0);
            tick(1);
        end
        chk("cfg_start_pulse", 32'(o_cfg_start), 1);
        tick(1);
        chk("cfg_start_single", 32'(o_cfg_start), 0);
        chk("cfg_wait_state", 32'(o_state), CFG_WAIT);

        // config done 10 cycles after start, continuous capture
        tick(8);
        i_cfg_done = 1'b1; i_mode = 1'b0;
        tick(1);
        i_cfg_done = 1'b0;
        chk("arm_state", 32'(o_state), ARM);
        chk("arm_frames_zero", 32'(o_frame_cnt), 0);
        i_vsync = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("capture_not_yet", 32'(o_capture_en), 0);
        end
        tick(1);
        chk("capture_after_4", 32'(o_capture_en), 1);
        i_vsync = 1'b0;
        tick(15);
        repeat (3) vs_pulse(3, 20);
        tick(5);
        chk("continuous_frames", 32'(o_frame_cnt), 3);
        chk("continuous_state", 32'(o_state), CAPTURE);

        // abort in the same cycle the sequencer sees a VSYNC rise
        i_vsync = 1'b1;
        tick(3);
        i_abort = 1'b1;
        tick(1);
        i_abort = 1'b0; i_vsync = 1'b0;
        chk("abort_state", 32'(o_state), HOLD);
        chk("abort_capture_off", 32'(o_capture_en), 0);
        chk("abort_no_count", 32'(o_frame_cnt), 3);
        tick(5);

        // snapshot: one frame, then HOLD; rearm without reconfiguring
        i_mode = 1'b1;
        cs0 = cs_cnt;
        cap_cnt = 0;
        go_pulse();
        repeat (3) vs_pulse(3, 20);
        chk("snap_capture_cycles", 32'(cap_cnt), 23);
        chk("snap_state", 32'(o_state), HOLD);
        chk("snap_frames", 32'(o_frame_cnt), 1);
        go_pulse();
        tick(10);
        chk("rearm_state", 32'(o_state), ARM);
        chk("rearm_no_cfg_start", 32'(cs_cnt), 32'(cs0));
        i_abort = 1'b1;
        tick(1);
        i_abort = 1'b0;
        chk("abort_in_arm", 32'(o_state), HOLD);

        // asynchronous reset in the middle of CAPTURE
        i_mode = 1'b0;
        go_pulse();
        vs_pulse(3, 10);
        chk("pre_reset_capture", 32'(o_state), CAPTURE);
        #2;
        i_rstn = 1'b0;
        model_reset();
        #1;
        chk("async_state", 32'(o_state), IDLE);
        chk("async_outputs", 32'({o_cam_reset, o_pwdn, o_cfg_rst, o_cfg_start, o_capture_en, o_busy, o_error}),
            32'(7'b0110000));
        chk("async_frames", 32'(o_frame_cnt), 0);
        tick(2);
        i_rstn = 1'b1;
        tick(2);

        // config timeout: two attempts then ERROR
        cs0 = cs_cnt;
        go_pulse();
        for (int i = 0; i < 300 && cs_cnt - cs0 < 2; i++) tick(1);
        chk("timeout_two_starts", 32'(cs_cnt - cs0), 2);
        tick(TC);
        chk("still_waiting", 32'(o_error), 0);
        tick(1);
        chk("error_flag", 32'(o_error), 1);
        chk("error_not_busy", 32'(o_busy), 0);
        chk("error_state", 32'(o_state), ERR);
        go_pulse();
        chk("restart_from_error", 32'(o_state), RST_HOLD);
        chk("restart_error_clear", 32'(o_error), 0);

        // randomized traffic, including occasional asynchronous resets
        for (int c = 0; c < 4000; c++) begin
            i_go = ($urandom_range(0, 39) == 0);
            i_mode = 1'($urandom_range(0, 1));
            i_abort = ($urandom_range(0, 149) == 0);
            i_cfg_done = ($urandom_range(0, 24) == 0);
            if (vs_left == 0) begin
                i_vsync = ~i_vsync;
                vs_left = $urandom_range(1, 40);
            end else vs_left--;
            if ($urandom_range(0, 999) == 0) begin
                i_rstn = 1'b0;
                model_reset();
            end else i_rstn = 1'b1;
            tick(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cam_sequencer.md
Name: cam_sequencer

Overview:
Single-clock control FSM that brings up the OV7670 and schedules frame capture. It drives camera RESET/PWDN, holds and pulses the SCCB configuration engine with retry-on-timeout, then gates the pixel-capture path with a capture enable aligned to VSYNC frame boundaries. It supports continuous and snapshot (single-frame) modes and sits between the debounced start button and the config and capture blocks.

Parameters:
RESET_CYCLES, 100_000, i_clk cycles o_cam_reset is held low (1 ms @100 MHz)
SETTLE_CYCLES, 1_000_000, cycles waited after reset release before configuring
CFG_TIMEOUT_CYCLES, 10_000_000, max cycles in CFG_WAIT before a retry
MAX_RETRIES, 3, configuration attempts before ERROR (>=1)
FRAME_CNT_W, 16, width of the frame counter

Ports:
i_clk  in  1  system clock
i_rstn  in  1  asynchronous active-low reset
i_go  in  1  start/rearm request, one-cycle pulse (already debounced)
i_mode  in  1  0 = continuous, 1 = snapshot; sampled on ARM entry
i_abort  in  1  level; forces stop of capture
i_vsync  in  1  camera VSYNC, asynchronous to i_clk
i_cfg_done  in  1  level done from config engine
o_cam_reset  out  1  OV7670 RESET, 0 = reset
o_pwdn  out  1  OV7670 PWDN, 1 = power down
o_cfg_rst  out  1  active-high reset to config engine
o_cfg_start  out  1  one-cycle start pulse to config engine
o_capture_en  out  1  enables pixel capture (cam_done input of capture block)
o_busy  out  1  high in every state except IDLE, HOLD, ERROR
o_error  out  1  high only in ERROR
o_frame_cnt  out  FRAME_CNT_W  frames captured since last ARM
o_state  out  4  current state encoding, debug

Behaviour:
- Reset (async, i_rstn=0): state IDLE; o_cam_reset=0, o_pwdn=1, o_cfg_rst=1, o_cfg_start=0, o_capture_en=0, o_busy=0, o_error=0, o_frame_cnt=0, retry count=0, all timers=0, VSYNC synchronizer=0.
- VSYNC: 2-FF synchronizer plus edge register; vs_rise is a one-cycle pulse, 3 cycles after i_vsync rises. Only rising edges are used.
- IDLE(0): pwdn=1, cam_reset=0, cfg_rst=1. i_go -> RST_HOLD with retry count=0.
- RST_HOLD(1): pwdn=0, cam_reset=0, cfg_rst=1. Stays exactly RESET_CYCLES cycles -> SETTLE.
- SETTLE(2): cam_reset=1, cfg_rst=0. Stays exactly SETTLE_CYCLES cycles -> CFG_START.
- CFG_START(3): o_cfg_start=1 for exactly this one cycle -> CFG_WAIT. The timer clears.
- CFG_WAIT(4): i_cfg_done=1 -> ARM. Otherwise, after CFG_TIMEOUT_CYCLES cycles the retry count increments. If the new count < MAX_RETRIES -> RST_HOLD. Else -> ERROR. If done and timeout occur in the same cycle, done wins.
- ARM(5): latch i_mode; o_frame_cnt=0; capture_en=0. The next vs_rise -> CAPTURE with capture_en=1 from the following cycle. This ensures capture never starts mid-frame.
- CAPTURE(6): capture_en=1. Each vs_rise increments o_frame_cnt, saturating at all-ones.
  - Snapshot mode: the first vs_rise in CAPTURE (one full frame) clears capture_en in the same transition -> HOLD.
  - Continuous mode: stays in CAPTURE.
- HOLD(7): capture_en=0, camera stays configured, frame_cnt holds. i_go -> ARM. No reconfiguration occurs.
- ERROR(8): o_error=1, cam_reset=0, cfg_rst=1, pwdn=0. i_go -> RST_HOLD with retry count=0.
- i_abort=1 in ARM or CAPTURE -> HOLD next cycle with capture_en=0. i_abort has priority over vs_rise. i_abort is ignored in other states.
- i_go is ignored in RST_HOLD, SETTLE, CFG_START, CFG_WAIT, ARM and CAPTURE.
- Unused state encodings -> IDLE.
- All outputs are registered. Output values in each state are valid in the first cycle of that state.

Test Plan:
All tests use RESET_CYCLES=4, SETTLE_CYCLES=8, CFG_TIMEOUT_CYCLES=50, MAX_RETRIES=2.
- Power-up: release i_rstn, pulse i_go -> o_cam_reset low 4 cycles, then high. o_cfg_start is a single pulse exactly 8 cycles after reset release. o_busy=1 throughout.
- Config success: raise i_cfg_done 10 cycles after start -> ARM. Toggle i_vsync -> o_capture_en=1 starting 4 cycles after the i_vsync rise. Continuous mode with 3 further VSYNC pulses -> o_frame_cnt=3.
- Snapshot: i_mode=1, run 3 VSYNC pulses after ARM -> capture_en high for exactly one VSYNC period, then state HOLD with o_frame_cnt=1. A further i_go rearms without a new o_cfg_start.
- Timeout/retry: never assert i_cfg_done -> two o_cfg_start pulses, each followed by the RST_HOLD sequence. 50 cycles after the second start: o_error=1, o_busy=0. i_go restarts the sequence.
- Abort: i_abort in CAPTURE in the same cycle as vs_rise -> o_capture_en=0 next cycle, state HOLD, frame_cnt not incremented.
- Async reset mid-CAPTURE: drop i_rstn -> all outputs return to reset values immediately without a clock edge, and state=IDLE.
